serial_addsub: RTL and testbench

//   Parametrised multi-cycle adder/subtractor built from chained full-adder cells.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/adder_digit.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/serial_addsub.sv | 98 +++++++++
 tb/tb_serial_addsub.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared FSM encoding and elaboration helpers for the digit-serial adder/subtractor.
// Pure declarations: no latency, no flow control.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-digit configuration still needs a 1-bit index register.
  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  function automatic bit digit_cfg_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/adder_digit.sv
// DIGIT-bit ripple of full_adder cells; combinational, no flow control.
// c_msb exposes the carry into the top bit so the caller can derive signed overflow.
module adder_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/sub, LSB digit first: start accepted in IDLE/DONE, busy for WIDTH/DIGIT cycles,
// then a one-cycle done pulse; start while busy is dropped, results hold until the next done.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = idx_width(NDIG);
  localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

  if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
    $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic             accept;
  logic [DIGIT-1:0] dig_s;
  logic             dig_co, dig_cmsb;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .ci    (carry),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the top so the LSB digit lands at bit 0 after NDIG shifts.
  assign res_nxt = (res_sr >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b ^ {WIDTH{sub}};
        carry <= sub ? 1'b1 : cin;
        idx   <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> DIGIT;
        b_sr   <= b_sr >> DIGIT;
        res_sr <= res_nxt;
        carry  <= dig_co;
        idx    <= idx + 1'b1;
        if (idx == LAST) begin
          sum      <= res_nxt;
          cout     <= dig_co;
          overflow <= dig_co ^ dig_cmsb;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench: three serial_addsub instances (DIGIT 4, 1, 16) share stimulus;
// expected sums and timings are hand-computed constants.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        busy_o [3];
  logic        done_o [3];
  logic [15:0] sum_o  [3];
  logic        cout_o [3];
  logic        ovf_o  [3];

  int n_chk  = 0;
  int n_pass = 0;

  localparam int DIG  [3] = '{4, 1, 16};
  localparam int NBSY [3] = '{4, 16, 1};
  localparam int LAT  [3] = '{5, 17, 2};

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]), .cout(cout_o[0]), .overflow(ovf_o[0])
  );
  serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]), .cout(cout_o[1]), .overflow(ovf_o[1])
  );
  serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_o[2]), .done(done_o[2]), .sum(sum_o[2]), .cout(cout_o[2]), .overflow(ovf_o[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // One operation on all three instances; checks timing, busy length and result.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tcin, input logic tsub,
                       input logic [15:0] es, input logic ec, input logic ev);
    int first [3];
    int ndone [3];
    int nbusy [3];
    int novl  [3];
    for (int j = 0; j < 3; j++) begin
      first[j] = 0; ndone[j] = 0; nbusy[j] = 0; novl[j] = 0;
    end
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~tcin; sub = ~tsub;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (busy_o[j]) nbusy[j]++;
        if (done_o[j]) begin
          ndone[j]++;
          if (first[j] == 0) first[j] = i;
        end
        if (busy_o[j] && done_o[j]) novl[j]++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_d%0d_lat", tag, DIG[j]), first[j], LAT[j]);
      chk($sformatf("%s_d%0d_busy", tag, DIG[j]), nbusy[j], NBSY[j]);
      chk($sformatf("%s_d%0d_ndone", tag, DIG[j]), ndone[j], 1);
      chk($sformatf("%s_d%0d_ovl", tag, DIG[j]), novl[j], 0);
      chk($sformatf("%s_d%0d_sum", tag, DIG[j]), sum_o[j], es);
      chk($sformatf("%s_d%0d_cout", tag, DIG[j]), cout_o[j], ec);
      chk($sformatf("%s_d%0d_ovf", tag, DIG[j]), ovf_o[j], ev);
    end
  endtask

  initial begin
    int seen;
    int nd;

    // reset state
    #3;
    for (int j = 0; j < 3; j++)
      chk($sformatf("rst_d%0d", DIG[j]),
          {busy_o[j], done_o[j], cout_o[j], ovf_o[j], sum_o[j]}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_o[0] || done_o[0] || cout_o[0] || ovf_o[0] || (sum_o[0] != 16'h0)) nd++;
    end
    chk("idle_quiet", nd, 0);

    do_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    do_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_cin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // back-to-back start at the done cycle, then a start pulse mid-RUN
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hFFFF; b = 16'h0001;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done_o[0]) begin seen = i; break; end
    end
    chk("b2b_first_done", seen, 5);
    chk("b2b_first_sum", sum_o[0], 16'h5555);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h0000; b = 16'h0000;
    @(negedge clk);
    chk("b2b_no_bubble", {busy_o[0], done_o[0]}, 2'b10);
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done_o[0]) begin seen = i; break; end
    end
    chk("b2b_second_done", seen, 3);
    chk("b2b_second_sum", sum_o[0], 16'h0000);
    chk("b2b_second_cout", cout_o[0], 1'b1);
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done_o[1]) begin seen = i; break; end
    end
    chk("busy_ignore_seen", (seen != 0), 1'b1);
    chk("busy_ignore_sum", sum_o[1], 16'h5555);
    repeat (20) @(posedge clk);

    // reset during the second RUN cycle aborts the operation
    #1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_was_busy", busy_o[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy_o[0], done_o[0], cout_o[0], ovf_o[0], sum_o[0]}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o[0]) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_sum", sum_o[0], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
